mem_bus_arbiter: RTL and testbench

Single-outstanding arbiter sharing one SRAM-like memory bus between the instruction-fetch port and the data-memory port of the pipeline. It sits between the datapath's fetch and mem stages and the cache/bus bridge. It serializes requests, holds the granted payload stable until the bus accepts it, and routes each response back to its owner. It also generates `stallreq_from_if` and `stallreq_from_mem` for the hazard unit, and discards an in-flight fetch response after a pipeline flush.

---
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one SRAM-like bus between the fetch (I) and data (D) ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build uses fixed D-over-I priority.
module mem_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_addr_ok,
  output logic          i_data_ok,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_wstrb,
  output logic          d_addr_ok,
  output logic          d_data_ok,
  output logic [DW-1:0] d_rdata,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_wstrb,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata,
  output logic          stallreq_from_if,
  output logic          stallreq_from_mem
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            discard_q, discard_d;
  logic            bus_wr_q, bus_wr_d;
  logic [1:0]      bus_size_q, bus_size_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]      bus_wstrb_q, bus_wstrb_d;
  logic            pick_dside;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // Contention goes to whichever port was not served last; lone requests win outright.
  assign pick_dside   = (i_req && d_req) ? ~last_grant_q : d_req;
  assign last_grant_d = (state_q == ST_IDLE && (i_req || d_req)) ? pick_dside : last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= GNT_I;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign pick_dside = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    discard_d   = discard_q;
    bus_wr_d    = bus_wr_q;
    bus_size_d  = bus_size_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    case (state_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        if (i_req || d_req) begin
          state_d = ST_ADDR;
          if (pick_dside) begin
            grant_d     = GNT_D;
            bus_wr_d    = d_wr;
            bus_size_d  = d_size;
            bus_addr_d  = d_addr;
            bus_wdata_d = d_wdata;
            bus_wstrb_d = d_wstrb;
          end else begin
            grant_d     = GNT_I;
            bus_wr_d    = 1'b0;
            bus_size_d  = 2'd2;
            bus_addr_d  = i_addr;
            bus_wdata_d = '0;
            bus_wstrb_d = 4'h0;
          end
        end
      end
      ST_ADDR: begin
        if (flush && grant_q == GNT_I) discard_d = 1'b1;
        if (bus_addr_ok) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (flush && grant_q == GNT_I) discard_d = 1'b1;
        if (bus_data_ok) begin
          state_d   = ST_IDLE;
          discard_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_I;
      discard_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= 2'd0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      discard_q   <= discard_d;
      bus_wr_q    <= bus_wr_d;
      bus_size_q  <= bus_size_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
    end
  end

  assign bus_req   = (state_q == ST_ADDR);
  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

  // A flush landing in the same cycle as the fetch data also suppresses it.
  assign i_addr_ok = bus_req && bus_addr_ok && (grant_q == GNT_I);
  assign d_addr_ok = bus_req && bus_addr_ok && (grant_q == GNT_D);
  assign i_data_ok = (state_q == ST_DATA) && bus_data_ok && (grant_q == GNT_I) && !discard_q && !flush;
  assign d_data_ok = (state_q == ST_DATA) && bus_data_ok && (grant_q == GNT_D);
  assign i_rdata   = bus_rdata;
  assign d_rdata   = bus_rdata;

  assign stallreq_from_if  = (i_req && !i_data_ok) || discard_q;
  assign stallreq_from_mem = (d_req && !d_data_ok) ||
                             ((grant_q == GNT_D) && (state_q == ST_DATA) && !bus_data_ok);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, reset corner case,
// and randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_addr_ok, i_data_ok;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [1:0]    d_size = 2'd0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_wstrb = 4'h0;
  logic          d_addr_ok, d_data_ok;
  logic [DW-1:0] d_rdata;
  logic          bus_req, bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [3:0]    bus_wstrb;
  logic          bus_addr_ok = 1'b0;
  logic          bus_data_ok = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic          stallreq_from_if, stallreq_from_mem;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_now();
    return {bus_req, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, stallreq_from_if, stallreq_from_mem};
  endfunction

  // Expected bus payload for an owner: D forwards its own fields, I is a word read.
  task automatic chk_payload(input string name, input logic own_d, input logic wr, input logic [1:0] sz,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [3:0] ws);
    if (own_d)
      chk(name, {bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb}, {wr, sz, a, wd, ws});
    else
      chk(name, {bus_wr, bus_size, bus_addr, bus_wstrb}, {1'b0, 2'd2, a, 4'h0});
  endtask

  // stim = {i_req, d_req, flush, bus_addr_ok, bus_data_ok}
  // exp  = {bus_req, owner_is_d, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, stall_if, stall_mem}
  typedef struct {
    logic [4:0] stim;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] s, input logic [7:0] e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    return v;
  endfunction

  // reference model state (one transaction record)
  logic          m_busy = 0, m_adone = 0, m_own_d = 0, m_drop = 0, m_last_d = 0;
  logic          m_wr = 0;
  logic [1:0]    m_sz = 0;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_wdata = 0;
  logic [3:0]    m_wstrb = 0;
  logic          e_breq, e_iaok = 0, e_daok = 0, e_idok, e_ddok, e_sif, e_smem, pick_d;

  initial begin
    // single fetch, simultaneous requests, flushed fetch, store with slow addr_ok
    vecs.push_back(mk(5'b00000, 8'b00000000));
    vecs.push_back(mk(5'b10000, 8'b00000010));
    vecs.push_back(mk(5'b10010, 8'b10100010));
    vecs.push_back(mk(5'b00001, 8'b00010000));
    vecs.push_back(mk(5'b00000, 8'b00000000));
    vecs.push_back(mk(5'b11000, 8'b00000011));
    vecs.push_back(mk(5'b11010, 8'b11001011));
    vecs.push_back(mk(5'b10001, 8'b00000110));
    vecs.push_back(mk(5'b10000, 8'b00000010));
    vecs.push_back(mk(5'b10010, 8'b10100010));
    vecs.push_back(mk(5'b00000, 8'b00000000));
    vecs.push_back(mk(5'b00001, 8'b00010000));
    vecs.push_back(mk(5'b00000, 8'b00000000));
    vecs.push_back(mk(5'b10000, 8'b00000010));
    vecs.push_back(mk(5'b10010, 8'b10100010));
    vecs.push_back(mk(5'b00100, 8'b00000000));
    vecs.push_back(mk(5'b00001, 8'b00000010));
    vecs.push_back(mk(5'b10000, 8'b00000010));
    vecs.push_back(mk(5'b10010, 8'b10100010));
    vecs.push_back(mk(5'b00001, 8'b00010000));
    vecs.push_back(mk(5'b00000, 8'b00000000));
    vecs.push_back(mk(5'b01000, 8'b00000001));
    vecs.push_back(mk(5'b01000, 8'b11000001));
    vecs.push_back(mk(5'b01000, 8'b11000001));
    vecs.push_back(mk(5'b01000, 8'b11000001));
    vecs.push_back(mk(5'b01010, 8'b11001001));
    vecs.push_back(mk(5'b00000, 8'b00000001));
    vecs.push_back(mk(5'b00001, 8'b00000100));
    vecs.push_back(mk(5'b00000, 8'b00000000));

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", ctrl_now(), 7'b0);
    chk("reset_payload", {bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb}, '0);
    $display("reset: ctrl=%b", ctrl_now());

    // directed table
    i_addr = 32'hBFC00000; d_addr = 32'h80000004; d_wr = 1'b1; d_size = 2'd2;
    d_wdata = 32'h12345678; d_wstrb = 4'hF; bus_rdata = 32'h3C1DBFC0;
    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk); #1;
      {i_req, d_req, flush, bus_addr_ok, bus_data_ok} = vecs[k].stim;
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", k), ctrl_now(), {vecs[k].exp[7], vecs[k].exp[5:0]});
      if (vecs[k].exp[7])
        chk_payload($sformatf("vec%0d_payload", k), vecs[k].exp[6], d_wr, d_size,
                    vecs[k].exp[6] ? d_addr : i_addr, d_wdata, d_wstrb);
      if (vecs[k].exp[4]) chk($sformatf("vec%0d_i_rdata", k), i_rdata, 32'h3C1DBFC0);
      if (vecs[k].exp[2]) chk($sformatf("vec%0d_d_rdata", k), d_rdata, 32'h3C1DBFC0);
      $display("vec %0d: stim=%b ctrl=%b", k, vecs[k].stim, ctrl_now());
    end

    // reset in ADDR while D owns the bus, then a stray bus_data_ok
    @(posedge clk); #1;
    {i_req, d_req, flush, bus_addr_ok, bus_data_ok} = 5'b01000;
    @(posedge clk); #1;
    chk("rstmid_breq_before", bus_req, 1'b1);
    #2 rst = 1'b1;
    #1 chk("rstmid_breq_async", bus_req, 1'b0);
    @(negedge clk); d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 {bus_addr_ok, bus_data_ok} = 2'b11;
    @(negedge clk);
    chk("rstmid_stray_ok", ctrl_now(), 7'b0);
    $display("reset mid-transaction: ctrl=%b", ctrl_now());
    @(posedge clk); #1 {bus_addr_ok, bus_data_ok} = 2'b00;

    // randomized traffic against the transaction model
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (i_req && e_iaok) i_req = 1'b0;
      else if (!i_req && $urandom_range(2) == 0) begin
        i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (d_req && e_daok) d_req = 1'b0;
      else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_addr = $urandom; d_wr = 1'($urandom_range(1));
        d_size = 2'($urandom_range(2)); d_wdata = $urandom; d_wstrb = 4'($urandom_range(15));
      end
      flush       = ($urandom_range(9) == 0);
      bus_addr_ok = 1'($urandom_range(1));
      bus_data_ok = ($urandom_range(2) == 0);
      bus_rdata   = $urandom;
      @(negedge clk);
      e_breq = m_busy && !m_adone;
      e_iaok = e_breq && !m_own_d && bus_addr_ok;
      e_daok = e_breq && m_own_d && bus_addr_ok;
      e_idok = m_busy && m_adone && !m_own_d && bus_data_ok && !m_drop && !flush;
      e_ddok = m_busy && m_adone && m_own_d && bus_data_ok;
      e_sif  = (i_req && !e_idok) || m_drop;
      e_smem = (d_req && !e_ddok) || (m_busy && m_adone && m_own_d && !bus_data_ok);
      chk($sformatf("rnd%0d_ctrl", c), ctrl_now(), {e_breq, e_iaok, e_idok, e_daok, e_ddok, e_sif, e_smem});
      if (e_breq) chk_payload($sformatf("rnd%0d_payload", c), m_own_d, m_wr, m_sz, m_addr, m_wdata, m_wstrb);
      chk($sformatf("rnd%0d_rdata", c), {i_rdata, d_rdata}, {bus_rdata, bus_rdata});
      // advance the model across the coming edge
      if (!m_busy) begin
        if (i_req || d_req) begin
`ifdef MEM_ARB_RR_EN
          pick_d = (i_req && d_req) ? !m_last_d : d_req;
`else
          pick_d = d_req;
`endif
          m_last_d = pick_d;
          m_busy = 1; m_adone = 0; m_drop = 0; m_own_d = pick_d;
          m_wr    = pick_d ? d_wr : 1'b0;
          m_sz    = pick_d ? d_size : 2'd2;
          m_addr  = pick_d ? d_addr : i_addr;
          m_wdata = d_wdata;
          m_wstrb = pick_d ? d_wstrb : 4'h0;
        end
      end else begin
        if (flush && !m_own_d) m_drop = 1;
        if (!m_adone) begin
          if (bus_addr_ok) m_adone = 1;
        end else if (bus_data_ok) begin
          $display("txn: owner=%s wr=%0d addr=%h dropped=%0d", m_own_d ? "D" : "I", m_wr, m_addr, m_drop);
          m_busy = 0; m_drop = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
